// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: AHB3-Lite transfer encodings and write-master state enum
package ahb3lite_pkg;
  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;
  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001
  } hburst_t;
  typedef enum logic [2:0] {
    SIZE_BYTE = 3'b000,
    SIZE_HALF = 3'b001,
    SIZE_WORD = 3'b010
  } hsize_t;
  typedef enum logic [1:0] {
    IDLE,
    XFER,
    LAST,
    ERR
  } state_t;
endpackage

// File: rtl/ahb3lite_write_master.sv
// ahb3lite_write_master: drains a word stream into an AHB3-Lite SINGLE/INCR write burst
module ahb3lite_write_master
  import ahb3lite_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      HADDR,
  output logic [31:0]      HWDATA,
  output logic             HWRITE,
  output logic [2:0]       HBURST,
  output logic [2:0]       HSIZE,
  output logic [1:0]       HTRANS,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic             busy,
  output logic             done,
  output logic             error
);
  state_t state, state_nx;
  htrans_t trans;
  logic [31:0] addr;
  logic [LEN_W-1:0] left;
  logic first, single, done_q, run;
  logic cmd_acc, pop, err_hit;
  assign cmd_ready = (state == IDLE) && run;
  assign cmd_acc = cmd_ready && cmd_valid;
  // a beat is only offered while its data is available; a stalled source holds wr_valid
  assign trans = (state != XFER) ? TR_IDLE :
                 !wr_valid ? (first ? TR_IDLE : TR_BUSY) :
                 (first || addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
  assign pop = (trans == TR_NONSEQ || trans == TR_SEQ) && HREADY;
  assign err_hit = (state == XFER || state == LAST) && HRESP && !HREADY;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (cmd_acc && cmd_len != '0) ? XFER : IDLE;
      XFER:    state_nx = err_hit ? ERR : (pop && left == LEN_W'(1)) ? LAST : XFER;
      LAST:    state_nx = err_hit ? ERR : HREADY ? IDLE : LAST;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      run    <= 1'b0;
      done_q <= 1'b0;
      addr   <= '0;
      left   <= '0;
      first  <= 1'b0;
      single <= 1'b0;
      HWDATA <= '0;
    end else begin
      state  <= state_nx;
      run    <= 1'b1;
      done_q <= (cmd_acc && cmd_len == '0) || (state == LAST && HREADY);
      if (cmd_acc) begin
        addr   <= cmd_addr;
        left   <= cmd_len;
        first  <= 1'b1;
        single <= cmd_len == LEN_W'(1);
      end
      if (pop) begin
        addr   <= addr + 32'd4;
        left   <= left - LEN_W'(1);
        first  <= 1'b0;
        HWDATA <= wr_data;
      end
    end
  end
  assign HTRANS   = trans;
  assign HADDR    = addr;
  assign HWRITE   = state != IDLE;
  assign HBURST   = (state != IDLE && !single) ? BURST_INCR : BURST_SINGLE;
  assign HSIZE    = SIZE_WORD;
  assign wr_ready = pop;
  assign busy     = state != IDLE;
  assign done     = done_q;
  assign error    = state == ERR;
endmodule
